// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched: round-robin scan of left load cell, right load cell and battery over the shared SPI A2D link.
// Latency: a start seen in IDLE pulses wrt one clock later; each result register updates the clock after its XFER2 done.
// Backpressure: a start while busy is held in a one-deep pending flag, and further starts are dropped; done is ignored outside XFER states.
// Optional: define BATT_FILT_EN so that batt reports the mean of the last four battery samples.
module a2d_scan_sched #(
  parameter int         PERIOD  = 4096,
  parameter int         GAP_CYC = 2,
  parameter logic [2:0] CH_LFT  = 3'd0,
  parameter logic [2:0] CH_RGHT = 3'd4,
  parameter logic [2:0] CH_BATT = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        scan_vld,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] XFER1 = 3'd1;
  localparam logic [2:0] GAP1  = 3'd2;
  localparam logic [2:0] XFER2 = 3'd3;
  localparam logic [2:0] GAP2  = 3'd4;

  localparam int CW = $clog2(PERIOD);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_q, pend_d;
  logic          wrt_q, wrt_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [11:0]   lft_q, lft_d;
  logic [11:0]   rght_q, rght_d;
  logic          vld_q, vld_d;
  logic          smp_we;
  logic          batt_we;
  logic          start;
  logic          done_ok;
  logic [2:0]    ch_sel;
  logic [15:0]   ch_cmd;

  assign start   = (cnt_q == CNT_LAST) | nxt;
  // The SPI master cannot finish a transaction in the cycle it is launched, so done is not accepted while wrt is high.
  assign done_ok = done & ~wrt_q;
  assign ch_sel  = (idx_q == 2'd0) ? CH_LFT : (idx_q == 2'd1) ? CH_RGHT : CH_BATT;
  assign ch_cmd  = {2'b00, ch_sel, 11'h000};
  assign batt_we = smp_we & (idx_q == 2'd2);

  // Next-state logic: period counter, pending start, scan sequencing and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    gap_d   = gap_q;
    pend_d  = pend_q | (start & (state_q != IDLE));
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = vld_q;
    smp_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start | pend_q) begin
          cmd_d   = ch_cmd;
          wrt_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = XFER1;
        end
      end
      XFER1: begin
        if (done_ok) begin
          gap_d   = '0;
          state_d = GAP1;
        end
      end
      GAP1: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          wrt_d   = 1'b1;
          state_d = XFER2;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      XFER2: begin
        if (done_ok) begin
          smp_we = 1'b1;
          gap_d  = '0;
          if (idx_q != 2'd2) begin
            idx_d   = idx_q + 2'd1;
            state_d = GAP2;
          end else begin
            idx_d   = 2'd0;
            vld_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      GAP2: begin
        // idx_q already points at the next channel here, so ch_cmd is its address.
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          cmd_d   = ch_cmd;
          wrt_d   = 1'b1;
          state_d = XFER1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    lft_d  = (smp_we && idx_q == 2'd0) ? rd_data[11:0] : lft_q;
    rght_d = (smp_we && idx_q == 2'd1) ? rd_data[11:0] : rght_q;
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      vld_q   <= vld_d;
    end
  end

`ifdef BATT_FILT_EN
  logic [11:0] hist_q [4];
  logic [13:0] sum_q;
  logic        unused_bits;

  // Four-sample moving sum: add the new sample and drop the oldest one leaving the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 14'h0000;
      for (int i = 0; i < 4; i++) hist_q[i] <= 12'h000;
    end else if (batt_we) begin
      sum_q     <= sum_q + {2'b00, rd_data[11:0]} - {2'b00, hist_q[3]};
      hist_q[0] <= rd_data[11:0];
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      hist_q[3] <= hist_q[2];
    end
  end

  assign batt        = sum_q[13:2];
  assign unused_bits = ^{rd_data[15:12], sum_q[1:0]};
`else
  logic [11:0] batt_q;
  logic        unused_bits;

  // Raw battery result, replaced on each battery conversion.
  always_ff @(posedge clk) begin
    if (rst) batt_q <= 12'h000;
    else if (batt_we) batt_q <= rd_data[11:0];
  end

  assign batt        = batt_q;
  assign unused_bits = ^rd_data[15:12];
`endif

  assign wrt      = wrt_q;
  assign cmd      = cmd_q;
  assign lft_ld   = lft_q;
  assign rght_ld  = rght_q;
  assign scan_vld = vld_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_scan_sched.sv
// Bench for a2d_scan_sched: an SPI responder, a timeline-level scan model checked every cycle, and directed scenarios.
module tb_a2d_scan_sched;
  localparam int PERIOD = 4096;
  localparam int GAP    = 2;
  localparam int LAT    = 6;

  logic        clk = 1'b0;
  logic        rst, nxt, done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        scan_vld, busy;

  a2d_scan_sched #(.PERIOD(PERIOD), .GAP_CYC(GAP), .CH_LFT(3'd0), .CH_RGHT(3'd4), .CH_BATT(3'd5)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done), .rd_data(rd_data),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt), .scan_vld(scan_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  // ---------------- behavioural model (timeline of transactions) ----------------
  int          CH [3] = '{0, 4, 5};
  logic [15:0] SEQ [6] = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
  bit          m_init = 0, m_act = 0, m_pend = 0, m_vld = 0;
  int          m_txn = 0, m_due = -10, rst_base = 0;
  logic [15:0] m_cmd = 16'h0000;
  logic [11:0] m_res [3];
  logic [11:0] m_bq  [4];

  function automatic logic [11:0] exp_batt();
`ifdef BATT_FILT_EN
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(m_bq[i]);
    return 12'(s / 4);
`else
    return m_res[2];
`endif
  endfunction

  function automatic logic [11:0] lit_batt(input int scans);
`ifdef BATT_FILT_EN
    case (scans)
      1:       return 12'h280;
      2:       return 12'h500;
      3:       return 12'h780;
      default: return 12'hA00;
    endcase
`else
    return (scans > 0) ? 12'hA00 : 12'h000;
`endif
  endfunction

  always @(posedge clk) begin : model
    bit st;
    if (rst === 1'b1) begin
      m_init = 1; m_act = 0; m_pend = 0; m_vld = 0; m_txn = 0; m_due = -10; m_cmd = 16'h0000;
      for (int i = 0; i < 3; i++) m_res[i] = 12'h000;
      for (int i = 0; i < 4; i++) m_bq[i] = 12'h000;
      rst_base = cyc + 1;
    end else if (m_init) begin
      st = (nxt === 1'b1) || (((cyc - rst_base) % PERIOD) == PERIOD - 1);
      if (!m_act) begin
        if (st || m_pend) begin
          m_act = 1; m_pend = 0; m_txn = 0; m_due = cyc + 1;
        end
      end else begin
        if (st) m_pend = 1;
        if (done === 1'b1 && cyc > m_due) begin
          if (m_txn % 2 == 1) begin
            m_res[m_txn / 2] = rd_data[11:0];
            if (m_txn == 5) begin
              for (int i = 3; i > 0; i--) m_bq[i] = m_bq[i-1];
              m_bq[0] = rd_data[11:0];
            end
          end
          if (m_txn == 5) begin
            m_act = 0; m_vld = 1;
          end else begin
            m_txn++; m_due = cyc + GAP + 1;
          end
        end
      end
      if (m_act && m_due == cyc + 1) m_cmd = 16'(CH[m_txn / 2] * 2048);
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    if (m_init) begin
      chk("wrt",      {31'd0, wrt},      {31'd0, m_act && (cyc == m_due)});
      chk("busy",     {31'd0, busy},     {31'd0, m_act});
      chk("cmd",      {16'd0, cmd},      {16'd0, m_cmd});
      chk("lft_ld",   {20'd0, lft_ld},   {20'd0, m_res[0]});
      chk("rght_ld",  {20'd0, rght_ld},  {20'd0, m_res[1]});
      chk("batt",     {20'd0, batt},     {20'd0, exp_batt()});
      chk("scan_vld", {31'd0, scan_vld}, {31'd0, m_vld});
    end
  end

  // ---------------- SPI slave responder ----------------
  bit          hold = 0, inj = 0;
  int          force_cyc = -1;
  logic [11:0] val_l, val_r, val_b;
  int          r_due = -1, r_inj = -1, n_wr = 0;
  bit          r_res = 0;
  logic [2:0]  r_ch = 3'd0;

  always @(negedge clk) begin : spi
    done    = 1'b0;
    rd_data = 16'hBEEF;
    if (rst !== 1'b0) begin
      n_wr = 0; r_due = -1; r_inj = -1;
    end else begin
      if (wrt === 1'b1) begin
        if (!(hold && (n_wr % 2 == 1) && cmd == 16'h2000)) begin
          r_due = cyc + LAT; r_res = (n_wr % 2 == 1); r_ch = cmd[13:11];
        end
        n_wr++;
      end
      if (cyc == r_due) begin
        done = 1'b1;
        if (r_res) rd_data = {4'hC, (r_ch == 3'd0) ? val_l : (r_ch == 3'd4) ? val_r : val_b};
        else begin
          rd_data = 16'hD0D0;
          if (inj) r_inj = cyc + 2;
        end
      end
      if (cyc == r_inj) begin done = 1'b1; rd_data = 16'hFFFF; end
      if (cyc == force_cyc) begin done = 1'b1; rd_data = 16'h0ABC; end
    end
  end

  logic [15:0] wq [$];
  always @(negedge clk) begin : collect
    if (wrt === 1'b1) wq.push_back(cmd);
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_wrt(input int budget, input string nm, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (wrt === 1'b1) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) timeout(nm);
  endtask

  task automatic wait_idle(input int budget, input string nm, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (busy === 1'b0) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) timeout(nm);
  endtask

  task automatic pulse_nxt(output int n);
    nxt = 1'b1;
    n = cyc;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  initial begin
    int t, n, tb0, i0, base;
    rst = 1'b1; nxt = 1'b0;
    val_l = 12'h150; val_r = 12'h156; val_b = 12'hA00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cyc;

    // Automatic scan after a full period, no nxt.
    i0 = wq.size();
    wait_wrt(5000, "first_wrt", t);
    chk("first_wrt_cycle", t - base, 4096);
    chk("first_cmd", {16'd0, cmd}, 32'h0);
    chk("vld_at_first_wrt", {31'd0, scan_vld}, 32'd0);
    wait_idle(200, "scan1_idle", t);
    chk("scan1_lft", {20'd0, lft_ld}, 32'h150);
    chk("scan1_rght", {20'd0, rght_ld}, 32'h156);
    chk("scan1_batt", {20'd0, batt}, {20'd0, lit_batt(1)});
    chk("scan1_vld", {31'd0, scan_vld}, 32'd1);
    chk("scan1_wrts", wq.size() - i0, 6);
    for (int k = 0; k < 6; k++)
      chk("scan1_cmd_seq", (i0 + k < wq.size()) ? {16'd0, wq[i0 + k]} : 32'hFFFF_FFFF, {16'd0, SEQ[k]});

    // nxt-triggered scan with new load-cell values.
    val_l = 12'h3A5; val_r = 12'h05C;
    repeat (4) @(negedge clk);
    i0 = wq.size();
    pulse_nxt(n);
    wait_wrt(20, "scan2_wrt", t);
    chk("nxt_to_wrt", t - n, 1);
    wait_idle(200, "scan2_idle", t);
    chk("scan2_lft", {20'd0, lft_ld}, 32'h3A5);
    chk("scan2_rght", {20'd0, rght_ld}, 32'h05C);
    chk("scan2_batt", {20'd0, batt}, {20'd0, lit_batt(2)});
    chk("scan2_wrts", wq.size() - i0, 6);

    // Extra starts during a scan: one pending scan, the rest dropped.
    repeat (4) @(negedge clk);
    i0 = wq.size();
    pulse_nxt(n);
    repeat (10) @(negedge clk);
    pulse_nxt(n);
    repeat (10) @(negedge clk);
    pulse_nxt(n);
    wait_idle(200, "scan3_idle", tb0);
    chk("scan3_batt", {20'd0, batt}, {20'd0, lit_batt(3)});
    wait_wrt(5, "pend_wrt", t);
    chk("pend_start_delay", t - tb0, 1);
    wait_idle(200, "scan4_idle", t);
    chk("scan4_batt", {20'd0, batt}, {20'd0, lit_batt(4)});
    repeat (100) @(negedge clk);
    chk("pend_total_wrts", wq.size() - i0, 12);
    chk("pend_quiet_busy", {31'd0, busy}, 32'd0);

    // Stray done while idle, then stray done in GAP1 during a scan.
    force_cyc = cyc + 2;
    repeat (5) @(negedge clk);
    chk("idle_done_busy", {31'd0, busy}, 32'd0);
    chk("idle_done_lft", {20'd0, lft_ld}, 32'h3A5);
    inj = 1; val_l = 12'h7E1;
    i0 = wq.size();
    pulse_nxt(n);
    wait_idle(200, "scan5_idle", t);
    inj = 0;
    chk("gap_done_lft", {20'd0, lft_ld}, 32'h7E1);
    chk("gap_done_rght", {20'd0, rght_ld}, 32'h05C);
    chk("gap_done_wrts", wq.size() - i0, 6);

    // Reset while waiting in XFER2 for the right load cell.
    hold = 1;
    i0 = wq.size();
    pulse_nxt(n);
    for (int k = 0; k < 200 && wq.size() < i0 + 4; k++) @(negedge clk);
    if (wq.size() < i0 + 4) timeout("hold_fourth_wrt");
    repeat (10) @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'h0);
    chk("rst_lft", {20'd0, lft_ld}, 32'h0);
    chk("rst_rght", {20'd0, rght_ld}, 32'h0);
    chk("rst_batt", {20'd0, batt}, 32'h0);
    chk("rst_vld", {31'd0, scan_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    hold = 0;
    force_cyc = cyc + 3;
    repeat (8) @(negedge clk);
    chk("late_done_busy", {31'd0, busy}, 32'd0);
    chk("late_done_rght", {20'd0, rght_ld}, 32'h0);
    i0 = wq.size();
    pulse_nxt(n);
    wait_wrt(20, "restart_wrt", t);
    chk("restart_cmd", {16'd0, cmd}, 32'h0);
    wait_idle(200, "restart_idle", t);
    chk("restart_lft", {20'd0, lft_ld}, 32'h7E1);
    chk("restart_rght", {20'd0, rght_ld}, 32'h05C);
    chk("restart_batt", {20'd0, batt}, {20'd0, lit_batt(1)});
    chk("restart_vld", {31'd0, scan_vld}, 32'd1);
    chk("restart_wrts", wq.size() - i0, 6);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
